instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Front-end scheduler for the bit-serial core. It deserialises 16-bit instructions from a serial pin into a small instruction FIFO, then issues them one at a time to the execution FSM. Issue happens on a step-button pulse (step mode) or automatically (run mode). Its outputs feed the execution FSM's opcode/instr/inst_done/btn_edge inputs.

Parameters:
INSTR_W, 16, instruction width in bits; opcode is the low 4 bits, instr is bits INSTR_W-1:4.
DEPTH, 4, FIFO depth in instructions; power of 2, at least 2.
PTR_W, 2, log2(DEPTH).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset
ser_in  in  1  serial instruction bit, MSB first
ser_valid  in  1  ser_in is sampled on each clk edge where this is high
run_mode  in  1  0 = step mode, 1 = auto-run mode
btn_edge  in  1  one-cycle step pulse
flush  in  1  synchronous clear of FIFO, shifter and bit counter
exec_busy  in  1  high while the execution FSM is out of idle
opcode  out  4  opcode of the issued instruction
instr  out  INSTR_W-4  operand field of the issued instruction
inst_done  out  1  issued instruction is valid and not yet retired
start  out  1  one-cycle issue pulse to the execution FSM
fifo_count  out  PTR_W+1  FIFO occupancy, 0..DEPTH
fifo_full  out  1  fifo_count == DEPTH
fifo_empty  out  1  fifo_count == 0
overflow  out  1  sticky: a completed word was dropped

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: opcode=0, instr=0, inst_done=0, start=0, fifo_count=0, fifo_full=0, fifo_empty=1, overflow=0. Shifter, bit counter and pointers are 0; state is S_IDLE.
- Reset mid-operation abandons any partial word and any in-flight issue.
- Deserialiser:
  - Each ser_valid edge shifts ser_in into the LSB and increments the bit counter.
  - On the INSTR_W-th bit, the completed word, including that bit, is pushed at the same edge, and the counter wraps to 0.
- Push rules:
  - A push is accepted if fifo_count < DEPTH, or if a pop occurs at the same edge.
  - Otherwise the word is dropped and overflow is set. overflow is cleared only by rst; flush does not clear it.
  - Pointers wrap modulo DEPTH.
- Issue state machine (states S_IDLE, S_WAIT_HI, S_WAIT_LO):
  - S_IDLE: if fifo_empty=0 and (run_mode=1 or btn_edge=1), then at that edge:
    - pop the head into opcode/instr;
    - set inst_done=1 and start=1;
    - go to S_WAIT_HI.
  - S_WAIT_HI: start=0. When exec_busy=1, go to S_WAIT_LO.
  - S_WAIT_LO: when exec_busy=0, set inst_done=0 and go to S_IDLE. opcode/instr hold their last value.
  - Issue latency: start is high exactly one cycle, in the cycle after the issue decision.
  - In auto-run mode, back-to-back issue needs at least one cycle in S_IDLE between instructions.
- Pop eligibility is based on the registered fifo_empty. A word pushed at edge N is issuable at edge N+1 at the earliest; there is no bypass.
- btn_edge outside S_IDLE is ignored and not queued.
- Changing run_mode takes effect only in S_IDLE.
- flush:
  - Clears FIFO, pointers and bit counter.
  - Does not disturb the issue state machine or the instruction already issued.
  - flush has priority over a simultaneous push or pop: no pop occurs, and the completing word is discarded without setting overflow.
- fifo_count updates per edge: +1 on push only, -1 on pop only, unchanged on both.

Test Plan:
- Step mode, shift 16'hA5C8 (MSB first) via 16 ser_valid pulses, then btn_edge → start pulse 1 cycle later; opcode=4'h8, instr=12'hA5C; inst_done high; fifo_count 1→0.
- Release: exec_busy high 3 cycles then low → inst_done=0 the cycle after the fall; a btn_edge during busy produces no second start.
- Auto-run: load 4 words, run_mode=1, exec_busy pulses 2 cycles after each start → 4 starts in FIFO order, fifo_empty=1 at the end.
- Overflow: with the FIFO full and no pop, complete a 5th word → overflow=1, count stays 4, original head is unchanged. Repeat with a pop at the same edge as the 16th bit → push accepted, overflow stays 0.
- flush after 7 serial bits plus 2 queued words → count=0, counter=0; a following 16-bit word is captured intact.
- Assert rst while in S_WAIT_LO with 3 queued → all outputs at reset values immediately (asynchronous), state S_IDLE.

Source files
------------

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - serial instruction deserialiser, FIFO and issue sequencer
//
// Purpose: collects INSTR_W-bit instructions arriving MSB first on ser_in,
// queues them in a DEPTH-entry FIFO and hands them one at a time to the
// execution FSM, either on a step pulse or automatically in run mode.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   ser_in, ser_valid    serial instruction bit and its qualifier
//   run_mode             0 = step on btn_edge, 1 = issue automatically
//   btn_edge             one-cycle step pulse
//   flush                clears FIFO, shifter and bit counter
//   exec_busy            execution FSM is out of idle
//   opcode, instr        low 4 bits / upper field of the issued instruction
//   inst_done            issued instruction valid and not yet retired
//   start                one-cycle issue pulse
//   fifo_count/full/empty FIFO occupancy and flags
//   overflow             sticky: a completed word was dropped
module instr_sequencer #(
   parameter int INSTR_W = 16,
   parameter int DEPTH   = 4,
   parameter int PTR_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ser_in,
   input  logic               ser_valid,
   input  logic               run_mode,
   input  logic               btn_edge,
   input  logic               flush,
   input  logic               exec_busy,
   output logic [3:0]         opcode,
   output logic [INSTR_W-5:0] instr,
   output logic               inst_done,
   output logic               start,
   output logic [PTR_W:0]     fifo_count,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic               overflow
);

   localparam int                CNT_W    = $clog2(INSTR_W);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(INSTR_W - 1);
   localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_HI, S_WAIT_LO} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [INSTR_W-1:0]   shifter;
   logic [CNT_W-1:0]     bit_cnt;
   logic [INSTR_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [INSTR_W-1:0]   word_nxt;
   logic                 word_done;
   logic                 pop;
   logic                 push;
   logic                 drop;

   // The completing word includes the bit arriving at this edge.
   assign word_nxt  = {shifter[INSTR_W-2:0], ser_in};
   assign word_done = ser_valid && (bit_cnt == LAST_BIT);

   assign fifo_full  = (fifo_count == DEPTH_C);
   assign fifo_empty = (fifo_count == '0);

   // A full FIFO still accepts a word when the head leaves at the same edge.
   // Flush discards a completing word silently (no overflow).
   assign push = word_done && !flush && (!fifo_full || pop);
   assign drop = word_done && !flush && fifo_full && !pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Issue decision uses the registered occupancy, so a word pushed at an
   // edge cannot be popped at that same edge.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty && (run_mode || btn_edge) && !flush) begin
               pop       = 1'b1;
               state_nxt = S_WAIT_HI;
            end
         end
         S_WAIT_HI: begin
            if (exec_busy) begin
               state_nxt = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!exec_busy) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (flush) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (ser_valid) begin
         shifter <= word_nxt;
         bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      end
   end

   // Storage array carries no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= word_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         opcode    <= '0;
         instr     <= '0;
         inst_done <= 1'b0;
         start     <= 1'b0;
      end else begin
         start <= pop;
         if (pop) begin
            opcode    <= mem[rd_ptr][3:0];
            instr     <= mem[rd_ptr][INSTR_W-1:4];
            inst_done <= 1'b1;
         end else if (state == S_WAIT_LO && !exec_busy) begin
            inst_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
//
// Purpose: drives serial words, step/run issue, overflow, flush and reset
// cases; compares outputs against hand-computed constants.
// Ports: none (top-level bench).
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ser_in = 1'b0;
   logic        ser_valid = 1'b0;
   logic        run_mode = 1'b0;
   logic        btn_edge = 1'b0;
   logic        flush = 1'b0;
   logic        exec_busy = 1'b0;
   logic [3:0]  opcode;
   logic [11:0] instr;
   logic        inst_done;
   logic        start;
   logic [2:0]  fifo_count;
   logic        fifo_full;
   logic        fifo_empty;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] word;
      logic [3:0]  exp_op;
      logic [11:0] exp_instr;
   } vec_t;

   vec_t vecs [5];

   instr_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .ser_in     (ser_in),
      .ser_valid  (ser_valid),
      .run_mode   (run_mode),
      .btn_edge   (btn_edge),
      .flush      (flush),
      .exec_busy  (exec_busy),
      .opcode     (opcode),
      .instr      (instr),
      .inst_done  (inst_done),
      .start      (start),
      .fifo_count (fifo_count),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) begin
         ser_in    = w[i];
         ser_valid = 1'b1;
         tick();
      end
      ser_valid = 1'b0;
      ser_in    = 1'b0;
   endtask

   task automatic issue();
      btn_edge = 1'b1;
      tick();
      btn_edge = 1'b0;
   endtask

   task automatic release_inst(input int busy_cycles);
      exec_busy = 1'b1;
      repeat (busy_cycles) tick();
      exec_busy = 1'b0;
      tick();
      chk("release_inst_done", inst_done, 0);
   endtask

   task automatic check_issue(input string name, input logic [3:0] op, input logic [11:0] ins);
      chk({name, "_start"}, start, 1);
      chk({name, "_opcode"}, opcode, op);
      chk({name, "_instr"}, instr, ins);
      chk({name, "_inst_done"}, inst_done, 1);
   endtask

   initial begin : main
      logic [15:0] auto_w [4];
      logic [15:0] ovf_w [5];
      logic [15:0] rst_w [4];
      logic [15:0] w;
      bit          ok;

      vecs[0] = '{16'hFFFF, 4'hF, 12'hFFF};
      vecs[1] = '{16'h0000, 4'h0, 12'h000};
      vecs[2] = '{16'h8001, 4'h1, 12'h800};
      vecs[3] = '{16'h7FFE, 4'hE, 12'h7FF};
      vecs[4] = '{16'h1234, 4'h4, 12'h123};
      auto_w  = '{16'hC0D1, 16'h2E72, 16'h9B03, 16'h47F4};
      ovf_w   = '{16'h5A31, 16'h6B42, 16'h7C53, 16'h8D64, 16'h9E75};
      rst_w   = '{16'hAAA1, 16'hBBB2, 16'hCCC3, 16'hDDD4};

      // Reset state
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_opcode", opcode, 0);
      chk("rst_instr", instr, 0);
      chk("rst_inst_done", inst_done, 0);
      chk("rst_start", start, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_full", fifo_full, 0);
      chk("rst_empty", fifo_empty, 1);
      chk("rst_overflow", overflow, 0);

      // Step mode: A5C8, then busy release with a stray btn_edge
      shift_word(16'hA5C8);
      chk("step_count_before", fifo_count, 1);
      issue();
      check_issue("step_a5c8", 4'h8, 12'hA5C);
      chk("step_count_after", fifo_count, 0);
      tick();
      chk("step_start_one_cycle", start, 0);
      shift_word(16'h1234);
      chk("step_queued", fifo_count, 1);
      exec_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         btn_edge = (i == 1);
         tick();
         chk("busy_no_start", start, 0);
         chk("busy_inst_done", inst_done, 1);
      end
      btn_edge  = 1'b0;
      exec_busy = 1'b0;
      tick();
      chk("fall_inst_done", inst_done, 0);
      chk("btn_not_queued_count", fifo_count, 1);
      tick();
      chk("btn_not_queued_start", start, 0);
      issue();
      check_issue("step_1234", 4'h4, 12'h123);
      release_inst(1);

      // Table-driven step vectors
      for (int k = 0; k < 5; k++) begin
         shift_word(vecs[k].word);
         chk("vec_count_one", fifo_count, 1);
         issue();
         check_issue("vec", vecs[k].exp_op, vecs[k].exp_instr);
         chk("vec_empty", fifo_empty, 1);
         release_inst(1);
      end

      // Auto-run: 4 words in FIFO order
      for (int k = 0; k < 4; k++) shift_word(auto_w[k]);
      chk("auto_full", fifo_full, 1);
      chk("auto_count", fifo_count, 4);
      run_mode = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            tick();
            if (start) begin
               ok = 1'b1;
               break;
            end
         end
         chk("auto_start_seen", ok, 1);
         w = auto_w[k];
         chk("auto_opcode", opcode, w[3:0]);
         chk("auto_instr", instr, w[15:4]);
         tick();
         chk("auto_start_low", start, 0);
         exec_busy = 1'b1;
         tick();
         tick();
         exec_busy = 1'b0;
      end
      repeat (3) begin
         tick();
         chk("auto_no_extra_start", start, 0);
      end
      chk("auto_end_empty", fifo_empty, 1);
      chk("auto_end_done", inst_done, 0);
      run_mode = 1'b0;

      // Overflow: full FIFO, no pop
      for (int k = 0; k < 4; k++) shift_word(ovf_w[k]);
      chk("ovf_full", fifo_full, 1);
      shift_word(16'hDEAD);
      chk("ovf_set", overflow, 1);
      chk("ovf_count", fifo_count, 4);
      issue();
      check_issue("ovf_head", 4'h1, 12'h5A3);
      release_inst(1);
      chk("ovf_sticky", overflow, 1);

      // Overflow avoided: pop at the same edge as the 16th bit
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick();
      chk("ovf_rst_clear", overflow, 0);
      for (int k = 0; k < 4; k++) shift_word(ovf_w[k]);
      w = ovf_w[4];
      for (int i = 15; i >= 1; i--) begin
         ser_in    = w[i];
         ser_valid = 1'b1;
         tick();
      end
      ser_in    = w[0];
      btn_edge  = 1'b1;
      tick();
      ser_valid = 1'b0;
      btn_edge  = 1'b0;
      check_issue("pushpop_head", 4'h1, 12'h5A3);
      chk("pushpop_overflow", overflow, 0);
      chk("pushpop_count", fifo_count, 4);
      release_inst(1);
      for (int k = 1; k < 5; k++) begin
         w = ovf_w[k];
         issue();
         check_issue("pushpop_order", w[3:0], w[15:4]);
         release_inst(1);
      end
      chk("pushpop_drained", fifo_empty, 1);

      // Flush: 2 queued words plus 7 partial bits
      shift_word(16'h0F0F);
      shift_word(16'hF0F0);
      for (int i = 0; i < 7; i++) begin
         ser_in    = 1'b1;
         ser_valid = 1'b1;
         tick();
      end
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      chk("flush_pre_count", fifo_count, 2);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_count", fifo_count, 0);
      chk("flush_empty", fifo_empty, 1);
      chk("flush_keeps_opcode", opcode, 4'h5);
      chk("flush_keeps_instr", instr, 12'h9E7);
      shift_word(16'h3C96);
      chk("flush_word_count", fifo_count, 1);
      issue();
      check_issue("flush_word", 4'h6, 12'h3C9);
      release_inst(1);

      // Async reset while in S_WAIT_LO with 3 queued
      for (int k = 0; k < 4; k++) shift_word(rst_w[k]);
      issue();
      check_issue("rstmid_issue", 4'h1, 12'hAAA);
      chk("rstmid_count", fifo_count, 3);
      exec_busy = 1'b1;
      tick();
      tick();
      chk("rstmid_inst_done", inst_done, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_opcode", opcode, 0);
      chk("arst_instr", instr, 0);
      chk("arst_inst_done", inst_done, 0);
      chk("arst_start", start, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_full", fifo_full, 0);
      chk("arst_empty", fifo_empty, 1);
      chk("arst_overflow", overflow, 0);
      #1 rst = 1'b0;
      shift_word(16'h6E57);
      issue();
      check_issue("arst_idle_issue", 4'h7, 12'h6E5);
      exec_busy = 1'b0;
      release_inst(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
